// File: rtl/dmaster_bytes_to_packets.sv
// dmaster_bytes_to_packets
//   Decodes the framed byte stream coming from the JTAG/SPI bridge into an
//   Avalon-ST packet stream. The framing characters are SOP 0x7A, EOP 0x7B,
//   CHANNEL 0x7C and ESCAPE 0x7D. They are stripped from the stream and turn
//   into the out_startofpacket, out_endofpacket and out_channel sideband.
//   The output is a single register stage with full backpressure support.
//
// Ports
//   clk                single clock, rising edge
//   reset              synchronous, active-high
//   in_ready/valid/data      encoded byte input (ready/valid)
//   out_ready/valid          decoded output handshake
//   out_data                 decoded payload byte
//   out_channel              channel of the current byte (CHANNEL_WIDTH bits)
//   out_startofpacket/endofpacket  packet framing of the current byte
module dmaster_bytes_to_packets #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket
);

  localparam logic [7:0] SOP_CODE  = 8'h7A;
  localparam logic [7:0] EOP_CODE  = 8'h7B;
  localparam logic [7:0] CHAN_CODE = 8'h7C;
  localparam logic [7:0] ESC_CODE  = 8'h7D;

  logic                     pend_sop_q, pend_sop_d;
  logic                     pend_eop_q, pend_eop_d;
  logic                     expect_chan_q, expect_chan_d;
  logic                     escaped_q, escaped_d;
  logic [7:0]               chan_q, chan_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_data_q, out_data_d;
  logic [CHANNEL_WIDTH-1:0] out_channel_q, out_channel_d;
  logic                     out_sop_q, out_sop_d;
  logic                     out_eop_q, out_eop_d;

  logic                     accept;
  logic                     is_value;
  logic [7:0]               value;
  // Padding lets one slice serve both the truncating and the zero-extending case.
  logic [CHANNEL_WIDTH+7:0] chan_ext;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign chan_ext = {{CHANNEL_WIDTH{1'b0}}, chan_q};

  always_comb begin
    pend_sop_d    = pend_sop_q;
    pend_eop_d    = pend_eop_q;
    expect_chan_d = expect_chan_q;
    escaped_d     = escaped_q;
    chan_d        = chan_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    is_value      = 1'b0;
    value         = in_data;

    // The held byte is consumed; a byte accepted this cycle may reload it below.
    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (escaped_q) begin
        // An escaped byte is always a value, even when it matches a special code.
        is_value  = 1'b1;
        value     = in_data ^ 8'h20;
        escaped_d = 1'b0;
      end else begin
        unique case (in_data)
          SOP_CODE: begin
            pend_sop_d    = 1'b1;
            expect_chan_d = 1'b0;
          end
          EOP_CODE: begin
            pend_eop_d    = 1'b1;
            expect_chan_d = 1'b0;
          end
          CHAN_CODE: expect_chan_d = 1'b1;
          ESC_CODE:  escaped_d     = 1'b1;
          default:   is_value      = 1'b1;
        endcase
      end

      if (is_value) begin
        if (expect_chan_q) begin
          chan_d        = value;
          expect_chan_d = 1'b0;
        end else begin
          out_valid_d   = 1'b1;
          out_data_d    = value;
          out_channel_d = chan_ext[CHANNEL_WIDTH-1:0];
          out_sop_d     = pend_sop_q;
          out_eop_d     = pend_eop_q;
          pend_sop_d    = 1'b0;
          pend_eop_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_sop_q    <= 1'b0;
      pend_eop_q    <= 1'b0;
      expect_chan_q <= 1'b0;
      escaped_q     <= 1'b0;
      chan_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
    end else begin
      pend_sop_q    <= pend_sop_d;
      pend_eop_q    <= pend_eop_d;
      expect_chan_q <= expect_chan_d;
      escaped_q     <= escaped_d;
      chan_q        <= chan_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_channel       = out_channel_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;

endmodule

// File: tb/tb_dmaster_bytes_to_packets.sv
// Bench for dmaster_bytes_to_packets: directed framing scenarios with literal
// expected beats, followed by randomized traffic against a reference model.
module tb_dmaster_bytes_to_packets;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_ready;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          out_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [CW-1:0] out_channel;
  logic          out_startofpacket;
  logic          out_endofpacket;

  dmaster_bytes_to_packets #(.CHANNEL_WIDTH(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference model: decoder context plus the beat the output should present.
  bit         m_psop, m_peop, m_xch, m_esc;
  logic [7:0] m_chan;
  bit         m_ov, m_osop, m_oeop;
  logic [7:0] m_od, m_och;

  // Beats handed downstream, packed as {data, channel, sop, eop}.
  logic [17:0] got[$];

  task automatic model_reset();
    m_psop = 0; m_peop = 0; m_xch = 0; m_esc = 0; m_chan = 8'h00;
    m_ov = 0; m_od = 8'h00; m_och = 8'h00; m_osop = 0; m_oeop = 0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    logic [7:0] v;
    bit isv;
    isv = 0;
    v = b;
    if (m_esc) begin
      v = b ^ 8'h20; isv = 1; m_esc = 0;
    end else begin
      case (b)
        8'h7A: begin m_psop = 1; m_xch = 0; end
        8'h7B: begin m_peop = 1; m_xch = 0; end
        8'h7C: m_xch = 1;
        8'h7D: m_esc = 1;
        default: isv = 1;
      endcase
    end
    if (isv) begin
      if (m_xch) begin
        m_chan = v; m_xch = 0;
      end else begin
        m_ov = 1; m_od = v; m_och = m_chan;
        m_osop = m_psop; m_oeop = m_peop;
        m_psop = 0; m_peop = 0;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check after the next falling edge.
  task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit r);
    bit acc;
    reset = rst; in_valid = v; in_data = d; out_ready = r;
    #1;
    if (!rst) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!m_ov || r)});
      if (out_valid && r)
        got.push_back({out_data, out_channel, out_startofpacket, out_endofpacket});
    end
    if (rst) begin
      model_reset();
    end else begin
      acc = v && (!m_ov || r);
      if (m_ov && r) m_ov = 0;
      if (acc) model_accept(d);
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    if (m_ov || rst) begin
      chk("out_data", {24'b0, out_data}, {24'b0, m_od});
      chk("out_channel", {24'b0, out_channel}, {24'b0, m_och});
      chk("out_sop", {31'b0, out_startofpacket}, {31'b0, m_osop});
      chk("out_eop", {31'b0, out_endofpacket}, {31'b0, m_oeop});
    end
  endtask

  task automatic send(input logic [7:0] bytes[$]);
    foreach (bytes[i]) step(0, 1, bytes[i], 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 1);
  endtask

  task automatic expect_got(input string tag, input logic [17:0] exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(tag, {14'b0, got[i]}, {14'b0, exp[i]});
    got.delete();
  endtask

  initial begin
    logic [7:0] bytes[$];
    logic [17:0] exp[$];
    logic [7:0] rb;
    int sel;

    reset = 1; in_valid = 0; in_data = 0; out_ready = 0;
    model_reset();
    @(negedge clk);
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    #1 chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    got.delete();

    // Basic packet
    bytes = '{8'h7A, 8'h7C, 8'h00, 8'h41, 8'h7B, 8'h42};
    send(bytes); idle(2);
    exp = '{{8'h41, 8'h00, 2'b10}, {8'h42, 8'h00, 2'b01}};
    expect_got("basic", exp);

    // Escapes
    bytes = '{8'h7A, 8'h7D, 8'h5A, 8'h7B, 8'h7D, 8'h5D};
    send(bytes); idle(2);
    exp = '{{8'h7A, 8'h00, 2'b10}, {8'h7D, 8'h00, 2'b01}};
    expect_got("escape", exp);

    // Escaped channel byte, then channel persistence
    bytes = '{8'h7C, 8'h7D, 8'h5C, 8'h7A, 8'h7B, 8'h55};
    send(bytes); idle(2);
    exp = '{{8'h55, 8'h7C, 2'b11}};
    expect_got("chan", exp);
    bytes = '{8'h7A, 8'h11, 8'h7B, 8'h22};
    send(bytes); idle(2);
    exp = '{{8'h11, 8'h7C, 2'b10}, {8'h22, 8'h7C, 2'b01}};
    expect_got("chan_persist", exp);

    // Backpressure: held output, then release with no bubble
    step(0, 1, 8'h41, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h42, 0);
    step(0, 1, 8'h42, 1);
    step(0, 1, 8'h43, 1);
    idle(2);
    exp = '{{8'h41, 8'h7C, 2'b00}, {8'h42, 8'h7C, 2'b00}, {8'h43, 8'h7C, 2'b00}};
    expect_got("bp", exp);

    // Streaming 10 bytes back to back
    exp.delete();
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 8'(i), 1);
      exp.push_back({8'(i), 8'h7C, 2'b00});
    end
    idle(2);
    expect_got("stream", exp);

    // Reset mid-packet
    bytes = '{8'h7A, 8'h7D};
    send(bytes);
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h41, 1);
    idle(2);
    exp = '{{8'h41, 8'h00, 2'b00}};
    expect_got("reset_mid", exp);

    // Framing survives idle gaps
    step(0, 1, 8'h7A, 1); idle(5);
    step(0, 1, 8'h7B, 1); idle(3);
    step(0, 1, 8'h33, 1); idle(2);
    exp = '{{8'h33, 8'h00, 2'b11}};
    expect_got("idle_gap", exp);

    // Randomized traffic, specials weighted heavily
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 9);
      rb = (sel < 4) ? 8'(8'h7A + $urandom_range(0, 3)) : 8'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rb,
           ($urandom_range(0, 2) != 0));
    end
    got.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
